// File: rtl/mult_arbiter.sv
// mult_arbiter -- shares one iterative 18x18 unsigned multiplier among NREQ requesters.
//
// The arbiter grants one requester at a time in round-robin order and latches
// that requester's operands. It clears the multiplier for one cycle, then
// holds it running until it reports completion. The captured product is
// returned with a one-cycle ack to the granted requester.
//
// Optional feature: define MULT_ARB_TIMEOUT_EN to add a RUN watchdog. After
// TIMEOUT cycles without mul_done, the operation completes with err=1 and
// result=0. Without the macro there is no counter, RUN waits indefinitely,
// and err is tied 0.
//
// Ports:
//   CLK         clock, rising edge
//   RST         asynchronous reset, active low
//   req         one request bit per requester
//   opa, opb    18-bit operand slice per requester, slice i = [18i+17:18i]
//   ack         one-hot, one-cycle completion pulse
//   result      36-bit product, nonzero only while ack is set
//   err         watchdog flag, only meaningful with ack
//   mul_clr_n   active-low clear to the shared multiplier
//   mul_start   run enable to the shared multiplier
//   mul_a/mul_b latched operands to the shared multiplier
//   mul_done    multiplier completion flag
//   mul_result  multiplier product
module mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req,
    input  logic [18*NREQ-1:0]   opa,
    input  logic [18*NREQ-1:0]   opb,
    output logic [NREQ-1:0]      ack,
    output logic [35:0]          result,
    output logic                 err,
    output logic                 mul_clr_n,
    output logic                 mul_start,
    output logic [17:0]          mul_a,
    output logic [17:0]          mul_b,
    input  logic                 mul_done,
    input  logic [35:0]          mul_result
);

    localparam int OP_W  = 18;
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    gnt_q, gnt_d;
    logic [OP_W-1:0]     mul_a_q, mul_a_d;
    logic [OP_W-1:0]     mul_b_q, mul_b_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic [35:0]         result_q, result_d;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    // Round-robin search: first set request bit at or after ptr_q, wrapping.
    logic                found;
    logic [PTR_W-1:0]    pick;
    int                  idx;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        ack_d    = '0;
        result_d = '0;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = pick;
                    ptr_d   = (pick == PTR_W'(NREQ - 1)) ? '0 : pick + 1'b1;
                    mul_a_d = opa[OP_W*int'(pick) +: OP_W];
                    mul_b_d = opb[OP_W*int'(pick) +: OP_W];
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = RUN;
`ifdef MULT_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            RUN: begin
                // A completion on the same edge as the watchdog expiry wins.
                if (mul_done) begin
                    state_d       = RESP;
                    ack_d         = '0;
                    ack_d[gnt_q]  = 1'b1;
                    result_d      = mul_result;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d       = RESP;
                    ack_d         = '0;
                    ack_d[gnt_q]  = 1'b1;
                    err_d         = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            ack_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            ack_q    <= ack_d;
            result_q <= result_d;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // The multiplier clear follows RST directly so it is held low during
    // reset and released as soon as the arbiter sits in IDLE.
    assign mul_clr_n = RST & (state_q != CLEAR);
    assign mul_start = (state_q == RUN);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign ack       = ack_q;
    assign result    = result_q;

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

    localparam int TO = 32;
    localparam int NEVER = 32'h7fffffff;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [3:0]   req = '0;
    logic [71:0]  opa = '0;
    logic [71:0]  opb = '0;
    logic [3:0]   ack;
    logic [35:0]  result;
    logic         err;
    logic         mul_clr_n;
    logic         mul_start;
    logic [17:0]  mul_a;
    logic [17:0]  mul_b;
    logic         mul_done;
    logic [35:0]  mul_result;

    mult_arbiter #(.NREQ(4), .TIMEOUT(TO)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .opa        (opa),
        .opb        (opb),
        .ack        (ack),
        .result     (result),
        .err        (err),
        .mul_clr_n  (mul_clr_n),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Shared multiplier model: done rises lat cycles after mul_start.
    int          lat_cfg = 19;
    int          cur_lat = 19;
    int          mcnt    = 0;
    logic        done_r  = 1'b0;
    logic        spur    = 1'b0;
    logic [35:0] mres    = '0;

    assign mul_done   = done_r | spur;
    assign mul_result = mres;

    always @(posedge CLK) begin
        if (!mul_clr_n || !mul_start) begin
            mcnt   <= 0;
            done_r <= 1'b0;
        end else if (!done_r && cur_lat != 0) begin
            if (mcnt == cur_lat - 1) begin
                done_r <= 1'b1;
                mres   <= {18'd0, mul_a} * {18'd0, mul_b};
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    // Reference model: per operation, the grant edge and the edge after which
    // the ack is visible, derived from the latency rule.
    bit          busy = 1'b0;
    logic [1:0]  mptr = '0;
    logic [1:0]  mg   = '0;
    int          gedge = 0;
    int          aedge = 0;
    logic [17:0] ea = '0;
    logic [17:0] eb = '0;
    logic [35:0] eprod = '0;
    logic        eerr = 1'b0;

    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [7:0] rot;
        rot = {r, r} >> p;
        for (int k = 0; k < 4; k++)
            if (rot[k]) return 2'(p + 2'(k));
        return p;
    endfunction

    always @(posedge CLK) begin
        cyc++;
        if (!RST) begin
            busy = 1'b0;
            mptr = '0;
            ea   = '0;
            eb   = '0;
        end else if (!busy && req != 4'b0) begin
            mg      = rr_pick(req, mptr);
            mptr    = mg + 2'd1;
            ea      = opa[18*mg +: 18];
            eb      = opb[18*mg +: 18];
            eprod   = {18'd0, ea} * {18'd0, eb};
            eerr    = 1'b0;
            busy    = 1'b1;
            gedge   = cyc;
            cur_lat = (lat_cfg < 0) ? int'($urandom_range(1, 40)) : lat_cfg;
`ifdef MULT_ARB_TIMEOUT_EN
            if (cur_lat != 0 && cur_lat < TO) begin
                aedge = cyc + 2 + cur_lat;
            end else begin
                aedge = cyc + 1 + TO;
                eerr  = 1'b1;
                eprod = '0;
            end
`else
            aedge = (cur_lat != 0) ? cyc + 2 + cur_lat : NEVER;
`endif
        end else if (busy && cyc == aedge + 1) begin
            busy = 1'b0;
        end
    end

    // Monitor: every cycle against the model, plus the clear-before-start rule.
    logic [3:0]  x_ack;
    logic [35:0] x_res;
    logic        x_err, x_clr, x_start;
    logic [17:0] x_a, x_b;
    int          low_run = 0;
    logic        prev_start = 1'b0;
    logic [3:0]  ack_log[$];
    logic [35:0] res_log[$];
    logic        err_log[$];

    always @(negedge CLK) begin
        if (!RST) begin
            x_ack = '0; x_res = '0; x_err = 1'b0; x_clr = 1'b0; x_start = 1'b0;
            x_a = '0; x_b = '0;
        end else begin
            x_ack   = (busy && cyc == aedge) ? (4'b0001 << mg) : 4'b0;
            x_res   = (busy && cyc == aedge) ? eprod : '0;
            x_err   = (busy && cyc == aedge) ? eerr : 1'b0;
            x_clr   = !(busy && cyc == gedge);
            x_start = busy && cyc > gedge && cyc < aedge;
            x_a     = ea;
            x_b     = eb;
        end
        check("ack", ack, x_ack);
        check("result", result, x_res);
        check("err", err, x_err);
        check("mul_clr_n", mul_clr_n, x_clr);
        check("mul_start", mul_start, x_start);
        check("mul_a", mul_a, x_a);
        check("mul_b", mul_b, x_b);
        if (RST && ack != 4'b0) begin
            ack_log.push_back(ack);
            res_log.push_back(result);
            err_log.push_back(err);
        end
        if (RST) begin
            if (mul_start && !prev_start) check("clr_pulse_len", 64'(low_run), 64'd1);
            low_run    = mul_clr_n ? 0 : low_run + 1;
            prev_start = mul_start;
        end else begin
            low_run    = 0;
            prev_start = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_acks(input int n, input int budget, input string tag);
        int k = 0;
        while (ack_log.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 64'(ack_log.size()), 64'(n));
    endtask

    task automatic clear_logs();
        ack_log.delete();
        res_log.delete();
        err_log.delete();
    endtask

    task automatic rand_ops();
        opa = {$urandom, $urandom, $urandom};
        opb = {$urandom, $urandom, $urandom};
    endtask

    logic [3:0] ord2 [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    logic [3:0] ord3 [3] = '{4'b0001, 4'b0010, 4'b0100};

    initial begin
        step(3);
        RST = 1'b1;
        step(2);

        // Single request, 3 x 5, multiplier takes 19 cycles.
        clear_logs();
        lat_cfg = 19;
        opa[17:0] = 18'd3;
        opb[17:0] = 18'd5;
        req = 4'b0001;
        step(1);
        req = 4'b0000;
        wait_acks(1, 60, "t1_wait");
        step(3);
        check("t1_count", 64'(ack_log.size()), 64'd1);
        check("t1_ack", ack_log[0], 4'b0001);
        check("t1_res", res_log[0], 36'd15);
        check("t1_err", err_log[0], 1'b0);

        // Reset so the pointer starts at 0, then two requesters held.
        RST = 1'b0;
        step(2);
        RST = 1'b1;
        step(1);
        clear_logs();
        lat_cfg = 3;
        rand_ops();
        req = 4'b0101;
        wait_acks(4, 100, "t2_wait");
        req = 4'b0000;
        for (int i = 0; i < 4; i++) check("t2_order", ack_log[i], ord2[i]);
        step(3);

        // Pointer now 3; three requesters held.
        clear_logs();
        rand_ops();
        req = 4'b0111;
        wait_acks(3, 100, "t3_wait");
        req = 4'b0000;
        for (int i = 0; i < 3; i++) check("t3_order", ack_log[i], ord3[i]);
        step(3);

        // Full-scale operands; operand changes during RUN are ignored.
        clear_logs();
        lat_cfg = 10;
        opa = '0; opb = '0;
        opa[17:0] = 18'h3FFFF;
        opb[17:0] = 18'h3FFFF;
        req = 4'b0001;
        step(1);
        req = 4'b0000;
        step(4);
        opa[17:0] = 18'h0;
        wait_acks(1, 40, "t4_wait");
        check("t4_res", res_log[0], 36'hFFFF80001);
        step(3);

        // Reset in RUN: no ack, next grant goes to the lowest index.
        clear_logs();
        lat_cfg = 15;
        rand_ops();
        req = 4'b0010;
        step(1);
        req = 4'b0000;
        step(5);
        RST = 1'b0;
        step(3);
        req = 4'b1010;
        check("t5_noack", 64'(ack_log.size()), 64'd0);
        RST = 1'b1;
        wait_acks(1, 60, "t5_wait");
        req = 4'b0000;
        check("t5_first", ack_log[0], 4'b0010);
        step(3);

        // Multiplier never completes.
        clear_logs();
        lat_cfg = 0;
        req = 4'b0001;
        step(1);
        req = 4'b0000;
`ifdef MULT_ARB_TIMEOUT_EN
        wait_acks(1, 60, "t6_wait");
        check("t6_err", err_log[0], 1'b1);
        check("t6_res", res_log[0], 36'd0);
        step(3);
`else
        step(60);
        check("t6_noack", 64'(ack_log.size()), 64'd0);
        RST = 1'b0;
        step(2);
        RST = 1'b1;
        step(1);
`endif

        // Randomized traffic with stray done pulses and occasional resets.
        lat_cfg = -1;
        for (int i = 0; i < 3000; i++) begin
            req  = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            rand_ops();
            spur = (!busy || cyc == gedge) && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 699) == 0) begin
                spur = 1'b0;
                RST  = 1'b0;
                step(2);
                RST  = 1'b1;
            end
            step(1);
        end
        spur = 1'b0;
        req  = 4'b0;
        step(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL be the number of requesters, fixed at 4 in this release.
REQ-002 Parameter TIMEOUT, default 32, SHALL be the watchdog limit in cycles; it is used only when MULT_ARB_TIMEOUT_EN is defined.
REQ-003 CLK  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 RST  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req  in  4  SHALL carry one request bit per requester.
REQ-006 opa  in  72  SHALL carry the multiplicand for requester i in bits [18i+17:18i].
REQ-007 opb  in  72  SHALL carry the multiplier for requester i in bits [18i+17:18i].
REQ-008 ack  out  4  SHALL be a one-hot, one-cycle completion pulse per requester.
REQ-009 result  out  36  SHALL be the product, valid only while ack is nonzero.
REQ-010 err  out  1  SHALL flag a timed-out operation and is valid only with ack.
REQ-011 mul_clr_n  out  1  SHALL be the active-low clear driven to the shared multiplier's reset.
REQ-012 mul_start  out  1  SHALL be the run enable driven to the shared multiplier.
REQ-013 mul_a, mul_b  out  18 each  SHALL be the latched operands driven to the shared multiplier.
REQ-014 mul_done  in  1  SHALL be the multiplier's completion flag.
REQ-015 mul_result  in  36  SHALL be the multiplier's product.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, RUN, RESP; any unused encoding SHALL return to IDLE.
REQ-017 IDLE: if any req bit is set, SHALL grant one requester by round-robin, latch its opa/opb slice into mul_a/mul_b, and go to CLEAR.
REQ-018 Round-robin: the search SHALL start at pointer ptr; after a grant to requester g, ptr SHALL become (g+1) mod 4.
REQ-019 CLEAR: SHALL drive mul_clr_n=0 for exactly one cycle with mul_start=0, then go to RUN.
REQ-020 RUN: SHALL hold mul_clr_n=1 and mul_start=1 until mul_done=1 is sampled, then capture mul_result and go to RESP.
REQ-021 RESP: for one cycle, SHALL drive ack[g]=1 and result=captured product; then SHALL drive mul_start=0 and go to IDLE.
REQ-022 Outside RESP, ack SHALL be 0 and result SHALL be 0.
REQ-023 Latency SHALL be 1 cycle from req to the CLEAR state, plus the multiplier time, plus 1 cycle from mul_done sampled to ack.
REQ-024 Operands SHALL be sampled only at grant; later changes to opa/opb SHALL NOT affect the operation in flight.
REQ-025 A req bit still high in the cycle after its ack SHALL be treated as a new request.
REQ-026 req changes during CLEAR, RUN or RESP SHALL have no effect until IDLE.
REQ-027 A requester that drops req before its ack SHALL still receive the ack; there is no cancellation.
REQ-028 mul_done=1 sampled in IDLE or CLEAR SHALL be ignored.
REQ-029 The product SHALL be the full unsigned 36-bit value, with no truncation.

Reset
REQ-030 While RST=0: state=IDLE, ptr=0, ack=0, result=0, err=0, mul_start=0, mul_a=0, mul_b=0, mul_clr_n=0.
REQ-031 Reset asserted mid-operation SHALL abort it immediately with no ack issued; the first grant after release SHALL use ptr=0.
REQ-032 After RST is released, mul_clr_n SHALL be 1 in IDLE.

Configuration
REQ-033 With MULT_ARB_TIMEOUT_EN defined:
- a counter SHALL clear on entry to RUN and increment each RUN cycle;
- on reaching TIMEOUT without mul_done, the block SHALL go to RESP with result=0 and err=1 for that ack;
- err SHALL be 0 for normal completions.
REQ-034 Without MULT_ARB_TIMEOUT_EN: there SHALL be no counter, RUN SHALL wait indefinitely, and err SHALL be tied 0.

Verification
REQ-035 req=0001, opa0=3, opb0=5, multiplier model done after 19 cycles -> ack=0001 for one cycle with result=15, err=0.
REQ-036 req=0101 held after each ack -> acks in order 0001, 0100, 0001, 0100; with req=0111 held and ptr=3 -> order 0001, 0010, 0100.
REQ-037 opa=opb=0x3FFFF -> result=0xFFFF80001; opa changed to 0 during RUN -> result unchanged.
REQ-038 RST pulsed low in RUN -> ack never asserted, mul_clr_n=0 and mul_start=0 during reset, next grant goes to lowest-index request.
REQ-039 With MULT_ARB_TIMEOUT_EN and mul_done stuck 0 -> ack exactly 32 RUN cycles after RUN entry, with err=1 and result=0; without the macro -> no ack.
REQ-040 Every operation -> mul_clr_n low for exactly one cycle before mul_start rises, checked by assertion.
